jk_seq_ctrl: RTL and testbench

Command-driven sequencer that owns a bank of WIDTH JK flip-flop cells and drives their J, K and enable inputs to implement clear, parallel load and bounded up/down counting. It sits between a simple command requester (test FSM or front-panel logic) and the JK register bank. It turns one accepted command into the exact per-bit J/K pattern over one or more clock cycles, then reports completion.

---
 rtl/jk_seq_ctrl_pkg.sv | 21 ++
 rtl/jk_seq_ctrl_cell.sv | 25 ++
 rtl/jk_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_jk_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_ctrl_pkg.sv
// Shared op codes and controller state encodings for the JK sequencer.
package jk_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic logic is_count(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_seq_ctrl_cell.sv
// One JK flip-flop with clock enable and asynchronous active-low clear.
module jk_seq_ctrl_cell (
  input  logic clk,
  input  logic Rn,
  input  logic en_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      q_o <= 1'b0;
    end else if (en_i) begin
      case ({j_i, k_i})
        2'b00: q_o <= q_o;
        2'b01: q_o <= 1'b0;
        2'b10: q_o <= 1'b1;
        2'b11: q_o <= ~q_o;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer: turns CLEAR/LOAD/UP/DOWN commands into per-bit J/K drive for a JK bank.
module jk_seq_ctrl
  import jk_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Rn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             pause,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q;
  op_e              op_q;
  logic             nop_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] remaining_q;
  logic             done_q;
  logic             wrap_q;

  logic             cell_en;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             step_wrap;
  op_e              cmd_op_e;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE) && Rn;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;

  // A zero-step count command still spends one APPLY cycle, but with the bank held.
  assign cell_en   = ((state_q == ST_APPLY) && !nop_q) || ((state_q == ST_RUN) && !pause);
  assign step_wrap = (op_q == OP_UP) ? (&Q) : (Q == '0);

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic ones_below;
    logic zeros_below;
    j_vec       = '0;
    k_vec       = '0;
    ones_below  = 1'b1;
    zeros_below = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (op_q)
        OP_CLEAR: begin j_vec[i] = 1'b0;        k_vec[i] = 1'b1;       end
        OP_LOAD:  begin j_vec[i] = load_q[i];   k_vec[i] = ~load_q[i]; end
        OP_UP:    begin j_vec[i] = ones_below;  k_vec[i] = ones_below; end
        OP_DOWN:  begin j_vec[i] = zeros_below; k_vec[i] = zeros_below; end
      endcase
      ones_below  = ones_below & Q[i];
      zeros_below = zeros_below & ~Q[i];
    end
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_CLEAR;
      nop_q       <= 1'b0;
      load_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op_e;
            load_q      <= cmd_arg;
            remaining_q <= cmd_arg;
            if (is_count(cmd_op_e) && (cmd_arg != '0)) begin
              state_q <= ST_RUN;
              nop_q   <= 1'b0;
            end else begin
              state_q <= ST_APPLY;
              nop_q   <= is_count(cmd_op_e);
            end
          end
        end
        ST_APPLY: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        ST_RUN: begin
          if (!pause) begin
            remaining_q <= remaining_q - WIDTH'(1);
            wrap_q      <= step_wrap;
            if (remaining_q == WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_seq_ctrl_cell u_cell (
      .clk  (clk),
      .Rn   (Rn),
      .en_i (cell_en),
      .j_i  (j_vec[g]),
      .k_i  (k_vec[g]),
      .q_o  (Q[g])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: directed scenarios plus random traffic against a counter-level model.
module tb_jk_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int MODV  = 16;

  localparam logic [1:0] C_CLEAR = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_UP    = 2'd2;
  localparam logic [1:0] C_DOWN  = 2'd3;

  logic             clk = 1'b0;
  logic             rn  = 1'b0;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             pause;
  logic             cmd_ready;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  int total = 0;
  int bad   = 0;

  jk_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .Rn        (rn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .Q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: the count as an integer, plus the pending job.
  int m_q     = 0;
  int m_left  = 0;
  int m_val   = 0;
  int m_op    = 0;
  bit m_busy  = 1'b0;
  bit m_apply = 1'b0;
  bit m_done  = 1'b0;
  bit m_wrap  = 1'b0;

  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_q = 0; m_left = 0; m_busy = 1'b0; m_apply = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
    end else begin
      m_done = 1'b0;
      m_wrap = 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy  = 1'b1;
          m_op    = int'(cmd_op);
          m_apply = 1'b1;
          if (m_op == 0)          m_val = 0;
          else if (m_op == 1)     m_val = int'(cmd_arg);
          else if (cmd_arg == 0)  m_val = m_q;
          else begin
            m_apply = 1'b0;
            m_left  = int'(cmd_arg);
          end
        end
      end else if (m_apply) begin
        m_q    = m_val;
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (!pause) begin
        if (m_op == 2) begin
          m_wrap = (m_q == MODV - 1);
          m_q    = (m_q + 1) % MODV;
        end else begin
          m_wrap = (m_q == 0);
          m_q    = (m_q + MODV - 1) % MODV;
        end
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("Q",     32'(q),         32'(m_q));
    check("busy",  32'(busy),      32'(m_busy));
    check("done",  32'(done),      32'(m_done));
    check("wrap",  32'(wrap),      32'(m_wrap));
    check("ready", 32'(cmd_ready), 32'(!m_busy && rn));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    check("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 1;
    while (done !== 1'b1 && edges < limit) begin
      tick();
      edges++;
    end
    if (done !== 1'b1) edges = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int edges;
    int up_exp[5];
    up_exp = '{14, 15, 0, 1, 2};
    cmd_valid = 1'b0;
    cmd_op    = C_CLEAR;
    cmd_arg   = '0;
    pause     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_Q",     32'(q),         32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_done",  32'(done),      32'd0);
    rn = 1'b1;
    #1 check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // LOAD 1010 then CLEAR
    issue(C_LOAD, 4'b1010);
    wait_done(10, n);
    check("load_edges", 32'(n), 32'd2);
    check("load_Q",     32'(q), 32'd10);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    issue(C_CLEAR, 4'd7);
    wait_done(10, n);
    check("clear_Q", 32'(q), 32'd0);

    // LOAD 1101 then UP 5, wrapping through zero
    issue(C_LOAD, 4'b1101);
    wait_done(10, n);
    issue(C_UP, 4'd5);
    edges = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      edges++;
      check("up_seq",  32'(q),    32'(up_exp[i]));
      check("up_wrap", 32'(wrap), 32'(up_exp[i] == 0));
    end
    check("up_done",  32'(done),  32'd1);
    check("up_edges", 32'(edges), 32'd6);

    // LOAD 0 then DOWN 2 with three paused cycles between steps
    issue(C_LOAD, 4'd0);
    wait_done(10, n);
    issue(C_DOWN, 4'd2);
    edges = 1;
    tick(); edges++;
    check("dn_q1",   32'(q),    32'd15);
    check("dn_wrap", 32'(wrap), 32'd1);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); edges++;
      check("dn_hold", 32'(q), 32'd15);
    end
    pause = 1'b0;
    tick(); edges++;
    check("dn_q2",    32'(q),     32'd14);
    check("dn_done",  32'(done),  32'd1);
    check("dn_edges", 32'(edges), 32'd6);

    // UP 0 with the next command held valid while busy
    issue(C_UP, 4'd0);
    cmd_valid = 1'b1;
    cmd_op    = C_LOAD;
    cmd_arg   = 4'd5;
    tick();
    check("nop_done",       32'(done), 32'd1);
    check("nop_Q",          32'(q),    32'd14);
    check("held_not_taken", 32'(busy), 32'd0);
    tick();
    check("held_taken", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    tick();
    check("held_Q", 32'(q), 32'd5);

    // Reset in the middle of a count
    issue(C_UP, 4'd10);
    tick();
    tick();
    rn = 1'b0;
    #1;
    check("abort_Q",     32'(q),         32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_done",  32'(done),      32'd0);
    tick();
    tick();
    rn = 1'b1;
    #1 check("abort_release_ready", 32'(cmd_ready), 32'd1);
    compare_all();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_arg   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      pause     = ($urandom_range(0, 3) == 0);
      if (i == 300) rn = 1'b0;
      if (i == 303) rn = 1'b1;
      tick();
    end

    cmd_valid = 1'b0;
    pause     = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
